// File: rtl/dbg_mem_req_arbiter_if.sv
// Bus bundle for dbg_mem_req_arbiter: requester-side request/response lanes
// plus the single downstream master path and status flags.
interface dbg_mem_req_arbiter_if #(
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 64
);
   // requester side
   logic [NUM_REQ-1:0]              req_i;
   logic [NUM_REQ-1:0]              gnt_o;
   logic [NUM_REQ*ADDR_WIDTH-1:0]   addr_i;
   logic [NUM_REQ-1:0]              we_i;
   logic [NUM_REQ*DATA_WIDTH-1:0]   wdata_i;
   logic [NUM_REQ*DATA_WIDTH/8-1:0] be_i;
   logic [NUM_REQ-1:0]              rvalid_o;
   logic [DATA_WIDTH-1:0]           rdata_o;
   logic                            err_o;

   // downstream side
   logic                            m_req_o;
   logic                            m_gnt_i;
   logic [ADDR_WIDTH-1:0]           m_addr_o;
   logic                            m_we_o;
   logic [DATA_WIDTH-1:0]           m_wdata_o;
   logic [DATA_WIDTH/8-1:0]         m_be_o;
   logic                            m_rvalid_i;
   logic [DATA_WIDTH-1:0]           m_rdata_i;
   logic                            m_err_i;

   // status
   logic                            busy_o;
   logic                            spurious_o;

   modport slave (
      input  req_i, addr_i, we_i, wdata_i, be_i,
      input  m_gnt_i, m_rvalid_i, m_rdata_i, m_err_i,
      output gnt_o, rvalid_o, rdata_o, err_o,
      output m_req_o, m_addr_o, m_we_o, m_wdata_o, m_be_o,
      output busy_o, spurious_o
   );

   modport master (
      output req_i, addr_i, we_i, wdata_i, be_i,
      output m_gnt_i, m_rvalid_i, m_rdata_i, m_err_i,
      input  gnt_o, rvalid_o, rdata_o, err_o,
      input  m_req_o, m_addr_o, m_we_o, m_wdata_o, m_be_o,
      input  busy_o, spurious_o
   );
endinterface

// File: rtl/dbg_mem_req_arbiter.sv
// Round-robin arbiter sharing one system-bus master path between NUM_REQ
// debug requesters, with an in-order ID FIFO routing responses back.
module dbg_mem_req_arbiter #(
   parameter int unsigned NUM_REQ         = 2,
   parameter int unsigned ADDR_WIDTH      = 64,
   parameter int unsigned DATA_WIDTH      = 64,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   dbg_mem_req_arbiter_if.slave bus
);
   localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned BW  = DATA_WIDTH / 8;

   typedef enum logic {ST_IDLE, ST_HOLD} state_t;

   state_t         state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW-1:0] sel_q, sel_d;
   logic [IDW-1:0] pick, cur;
   logic           found, full, push, pop, m_req;
   logic [CW-1:0]  cnt_q;
   logic [PW-1:0]  wr_q, rd_q;
   logic [IDW-1:0] fifo_q [MAX_OUTSTANDING];
   logic [IDW-1:0] head_id;
   logic           spur_q;

   logic [NUM_REQ-1:0]    gnt_vec, rvalid_vec;
   logic [ADDR_WIDTH-1:0] addr_sel;
   logic [DATA_WIDTH-1:0] wdata_sel;
   logic [BW-1:0]         be_sel;
   logic                  we_sel;

   function automatic logic [IDW-1:0] inc_id(input logic [IDW-1:0] k);
      return (32'(k) == NUM_REQ - 1) ? '0 : k + 1'b1;
   endfunction

   function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
      return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
   endfunction

   // Rotating-priority search starting at ptr_q.
   always_comb begin
      int unsigned j;
      logic [IDW-1:0] k;
      found = 1'b0;
      pick  = '0;
      j     = 0;
      k     = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         j = 32'(ptr_q) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         k = IDW'(j);
         if (!found && bus.req_i[k]) begin
            found = 1'b1;
            pick  = k;
         end
      end
   end

   assign full = (cnt_q == CW'(MAX_OUTSTANDING));

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cur     = sel_q;
      m_req   = 1'b0;
      push    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            cur = pick;
            if (found && !full) begin
               m_req = 1'b1;
               if (bus.m_gnt_i) begin
                  push  = 1'b1;
                  ptr_d = inc_id(pick);
               end else begin
                  sel_d   = pick;
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            // Held selection keeps driving even if its req_i drops.
            m_req = 1'b1;
            if (bus.m_gnt_i) begin
               push    = 1'b1;
               ptr_d   = inc_id(sel_q);
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign addr_sel  = bus.addr_i[cur*ADDR_WIDTH +: ADDR_WIDTH];
   assign wdata_sel = bus.wdata_i[cur*DATA_WIDTH +: DATA_WIDTH];
   assign be_sel    = bus.be_i[cur*BW +: BW];
   assign we_sel    = bus.we_i[cur];
   assign gnt_vec   = (m_req && bus.m_gnt_i) ? (NUM_REQ'(1) << cur) : '0;

   assign head_id    = fifo_q[rd_q];
   assign pop        = bus.m_rvalid_i && (cnt_q != '0);
   assign rvalid_vec = pop ? (NUM_REQ'(1) << head_id) : '0;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         spur_q  <= 1'b0;
         for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         if (push) begin
            fifo_q[wr_q] <= cur;
            wr_q         <= inc_ptr(wr_q);
         end
         if (pop) rd_q <= inc_ptr(rd_q);
         unique case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
         if (bus.m_rvalid_i && (cnt_q == '0)) spur_q <= 1'b1;
      end
   end

   // Combinational paths are forced low while reset is held.
   assign bus.m_req_o    = rstn_i & m_req;
   assign bus.gnt_o      = rstn_i ? gnt_vec : '0;
   assign bus.m_addr_o   = rstn_i ? addr_sel : '0;
   assign bus.m_we_o     = rstn_i & we_sel;
   assign bus.m_wdata_o  = rstn_i ? wdata_sel : '0;
   assign bus.m_be_o     = rstn_i ? be_sel : '0;
   assign bus.rvalid_o   = rstn_i ? rvalid_vec : '0;
   assign bus.rdata_o    = rstn_i ? bus.m_rdata_i : '0;
   assign bus.err_o      = rstn_i & bus.m_err_i;
   assign bus.busy_o     = rstn_i & (cnt_q != '0);
   assign bus.spurious_o = rstn_i & spur_q;

endmodule
